// File: rtl/divider_iterative.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU with a start/done handshake.
// Optional macro DIV_EARLY_TERM_EN: skip the iterations when |dividend| < |divisor|.
module divider_iterative #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             startE,
    input  logic [1:0]       div_opcode,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic [WIDTH-1:0] result_divide,
    output logic             done,
    output logic             div_use
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic             rem_sel_q, qneg_q, rneg_q;
    logic [WIDTH-1:0] rem_q, quo_q, dmag_q;
    logic [CNT_W-1:0] cnt_q;

    logic             is_signed, div_zero, overflow, fast_hit, early_hit;
    logic [WIDTH-1:0] mag1, mag2, fast_res, early_res, fix_res, diff;
    logic [WIDTH:0]   shifted;
    logic             fits;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        is_signed = ~div_opcode[0];
        mag1      = (is_signed && operand1[WIDTH-1]) ? -operand1 : operand1;
        mag2      = (is_signed && operand2[WIDTH-1]) ? -operand2 : operand2;
        div_zero  = (operand2 == '0);
        overflow  = is_signed && (operand1 == MIN_NEG) && (operand2 == '1);
        fast_hit  = div_zero || overflow;
        fast_res  = div_opcode[1] ? (div_zero ? operand1 : '0)
                                  : (div_zero ? '1 : MIN_NEG);
`ifdef DIV_EARLY_TERM_EN
        early_hit = !fast_hit && (mag1 < mag2);
`else
        early_hit = 1'b0;
`endif
        early_res = div_opcode[1] ? operand1 : '0;

        // One restoring step: the compare needs the extra bit shifted out of rem.
        shifted   = {rem_q, quo_q[WIDTH-1]};
        fits      = (shifted >= {1'b0, dmag_q});
        diff      = shifted[WIDTH-1:0] - dmag_q;
        fix_res   = rem_sel_q ? (rneg_q ? -rem_q : rem_q)
                              : (qneg_q ? -quo_q : quo_q);

        state_nxt = state;
        case (state)
            IDLE: if (startE) state_nxt = (fast_hit || early_hit) ? DONE : CALC;
            CALC: if (cnt_q == LAST_CNT) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign div_use = (state == CALC) || (state == FIX);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            done          <= 1'b0;
            result_divide <= '0;
            rem_sel_q     <= 1'b0;
            qneg_q        <= 1'b0;
            rneg_q        <= 1'b0;
            rem_q         <= '0;
            quo_q         <= '0;
            dmag_q        <= '0;
            cnt_q         <= '0;
        end else begin
            state <= state_nxt;
            done  <= (state_nxt == DONE);
            case (state)
                IDLE: if (startE) begin
                    rem_sel_q <= div_opcode[1];
                    qneg_q    <= is_signed && (operand1[WIDTH-1] ^ operand2[WIDTH-1]) && !div_zero;
                    rneg_q    <= is_signed && operand1[WIDTH-1];
                    dmag_q    <= mag2;
                    quo_q     <= mag1;
                    rem_q     <= '0;
                    cnt_q     <= '0;
                    if (fast_hit)       result_divide <= fast_res;
                    else if (early_hit) result_divide <= early_res;
                end
                CALC: begin
                    rem_q <= fits ? diff : shifted[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], fits};
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                FIX: result_divide <= fix_res;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_iterative.sv
// Self-checking bench for divider_iterative: table of directed vectors plus
// hand-written sequences for ignored starts, reset abort and done pulse width.
module tb_divider_iterative;

    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;
`ifdef DIV_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        startE = 1'b0;
    logic [1:0]  div_opcode = '0;
    logic [31:0] operand1 = '0, operand2 = '0;
    logic [31:0] result_divide;
    logic        done, div_use;

    int n_checks = 0;
    int n_fail   = 0;

    divider_iterative #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .startE(startE), .div_opcode(div_opcode),
        .operand1(operand1), .operand2(operand2),
        .result_divide(result_divide), .done(done), .div_use(div_use)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          fast;
        bit          early;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one request; optionally raise startE again after sample number inj_at.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int inj_at, output logic [31:0] res, output int lat, output int uses);
        bit seen;
        @(negedge clk);
        startE = 1'b1; div_opcode = op; operand1 = a; operand2 = b;
        @(posedge clk); #1;
        startE = 1'b0; div_opcode = 2'($urandom); operand1 = $urandom; operand2 = $urandom;
        seen = 1'b0; lat = -1; uses = 0; res = '0;
        for (int n = 1; n <= 60 && !seen; n++) begin
            if (div_use) uses++;
            if (n == inj_at) begin
                startE = 1'b1; div_opcode = OP_DIVU; operand1 = 32'd1000; operand2 = 32'd1;
            end else begin
                startE = 1'b0;
            end
            if (done) begin
                seen = 1'b1; lat = n; res = result_divide;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!seen) begin
            n_checks++; n_fail++;
            $display("FAIL timeout: no done within 60 edges (op=%0d a=0x%08h b=0x%08h)", op, a, b);
        end
        @(posedge clk); #1;
        startE = 1'b0;
        check("done_one_cycle", {31'b0, done}, 32'd0);
    endtask

    function automatic int exp_latency(input bit fast, input bit early);
        return (fast || (EARLY && early)) ? 1 : 34;
    endfunction

    initial begin
        logic [31:0] res;
        int lat, uses, el;

        //          op       dividend      divisor       expected      fast  early
        vecs[0]  = '{OP_DIVU, 32'd100,      32'd7,        32'h0000000E, 1'b0, 1'b0};
        vecs[1]  = '{OP_REMU, 32'd100,      32'd7,        32'h00000002, 1'b0, 1'b0};
        vecs[2]  = '{OP_DIV,  32'hFFFFFF9C, 32'h00000007, 32'hFFFFFFF2, 1'b0, 1'b0};
        vecs[3]  = '{OP_REM,  32'hFFFFFF9C, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[4]  = '{OP_DIV,  32'h00000064, 32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0, 1'b0};
        vecs[5]  = '{OP_REM,  32'h00000064, 32'hFFFFFFF9, 32'h00000002, 1'b0, 1'b0};
        vecs[6]  = '{OP_DIV,  32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[7]  = '{OP_REMU, 32'd5,        32'd0,        32'h00000005, 1'b1, 1'b0};
        vecs[8]  = '{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b0};
        vecs[9]  = '{OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0};
        vecs[10] = '{OP_DIVU, 32'd3,        32'd10,       32'h00000000, 1'b0, 1'b1};
        vecs[11] = '{OP_REM,  32'hFFFFFFFD, 32'd10,       32'hFFFFFFFD, 1'b0, 1'b1};
        vecs[12] = '{OP_DIVU, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[13] = '{OP_DIV,  32'h80000000, 32'd2,        32'hC0000000, 1'b0, 1'b0};
        vecs[14] = '{OP_REMU, 32'd0,        32'd5,        32'h00000000, 1'b0, 1'b1};
        vecs[15] = '{OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 1'b0};
        vecs[16] = '{OP_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_result", result_divide, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_div_use", {31'b0, div_use}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 17; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, -1, res, lat, uses);
            el = exp_latency(vecs[i].fast, vecs[i].early);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(el));
            check($sformatf("vec%0d_div_use_cycles", i), 32'(uses), (el == 34) ? 32'd33 : 32'd0);
        end

        // startE during CALC is ignored; the first result stands.
        run_op(OP_DIVU, 32'd100, 32'd7, 6, res, lat, uses);
        check("ignore_calc_result", res, 32'h0000000E);
        check("ignore_calc_latency", 32'(lat), 32'd34);

        // Second request after done is accepted; startE raised during DONE is ignored.
        run_op(OP_DIVU, 32'd1000, 32'd1, 34, res, lat, uses);
        check("second_result", res, 32'h000003E8);
        check("second_latency", 32'(lat), 32'd34);
        @(posedge clk); #1;
        check("ignore_done_div_use", {31'b0, div_use}, 32'd0);
        check("ignore_done_done", {31'b0, done}, 32'd0);

        // Reset in the middle of CALC aborts silently and clears the result.
        @(negedge clk);
        startE = 1'b1; div_opcode = OP_DIVU; operand1 = 32'd100; operand2 = 32'd7;
        @(posedge clk); #1;
        startE = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid_calc_div_use", {31'b0, div_use}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_div_use", {31'b0, div_use}, 32'd0);
        check("abort_result", result_divide, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run_op(OP_DIVU, 32'd9, 32'd3, -1, res, lat, uses);
        check("post_reset_result", res, 32'd3);
        check("post_reset_latency", 32'(lat), 32'd34);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/divider_iterative.md
Name: divider_iterative

Overview:
- Sequential radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- It is the responder side of the execute-stage M-extension start/done handshake, mirroring the iterative multiplier.
- The M-check issuing logic drives `startE`, `div_opcode` and operands, then stalls the pipeline on `div_use` until `done` pulses.
- It replaces the combinational divider on the execute-stage `result_divide` path.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-low (rst=0 resets on the next rising clk).
- startE  input  1  request strobe; accepted only in IDLE.
- div_opcode  input  2  00=DIV, 01=DIVU, 10=REM, 11=REMU; sampled with startE.
- operand1  input  WIDTH  dividend; sampled with startE.
- operand2  input  WIDTH  divisor; sampled with startE.
- result_divide  output  WIDTH  quotient or remainder; registered, held until the next accepted request.
- done  output  1  one-cycle completion pulse; result_divide is valid while done=1.
- div_use  output  1  busy/stall request; high in CALC and FIX.

Behaviour:
- Reset (rst=0 at an edge): state=IDLE, result_divide=0, done=0, div_use=0, counter=0, internal remainder/quotient=0. Reset mid-operation aborts with no done pulse.
- States: IDLE, CALC, FIX, DONE. div_use = (state==CALC | state==FIX), decoded combinationally from the state register. done = (state==DONE), registered.
- IDLE:
  - On an edge with startE=1, latch div_opcode and signed = ~div_opcode[0].
  - Latch magnitudes: |operand1|, |operand2| if signed, else raw values.
  - Latch qneg = signed & (op1[31]^op2[31]) & (op2!=0) and rneg = signed & op1[31].
  - Fast paths at the same edge, going directly to DONE:
    - operand2==0: quotient=all-ones, remainder=operand1.
    - signed & operand1==0x80000000 & operand2==0xFFFFFFFF: quotient=0x80000000, remainder=0.
    - Result selected by div_opcode[1] (1 = remainder).
  - Otherwise go to CALC with counter=0.
- CALC, one iteration per edge:
  - Shift {rem,quo} left by 1, bringing in the dividend MSB.
  - If rem_shifted >= divisor_mag (WIDTH+1-bit unsigned compare), subtract it and set the quotient LSB to 1.
  - After WIDTH iterations (counter==WIDTH-1 at the edge), go to FIX.
- FIX, one edge:
  - result_divide = div_opcode[1] ? (rneg ? -rem : rem) : (qneg ? -quo : quo).
  - Go to DONE.
- DONE, one edge: go to IDLE; result_divide holds.
- Latency:
  - Request accepted at edge E0. done is high during the cycle after edge E0+WIDTH+1 (34 edges for WIDTH=32), then drops at the following edge.
  - Fast path: done is high during the cycle after E0.
- startE outside IDLE, including in DONE, is ignored; operand changes after acceptance have no effect.
- Back-to-back: a new startE is accepted no earlier than the first IDLE cycle after done.
- Results are RISC-V-exact: quotient truncates toward zero; remainder sign follows the dividend.

Optional Feature:
- Macro DIV_EARLY_TERM_EN.
- Defined: in IDLE, when not a fast path and dividend_mag < divisor_mag (unsigned), skip CALC/FIX. Set quotient=0, remainder=operand1 and go directly to DONE, so done is high the cycle after E0.
- Not defined: every non-fast-path request takes the full WIDTH+2 latency; results are identical either way.

Test Plan:
- DIVU 100/7 -> done after 34 edges, result_divide=0x0000000E; REMU same operands -> 0x00000002; div_use high for exactly 33 cycles.
- DIV 0xFFFFFF9C/0x00000007 -> 0xFFFFFFF2; REM -> 0xFFFFFFFE; DIV 0x00000064/0xFFFFFFF9 -> 0xFFFFFFF2, REM -> 0x00000002.
- DIV 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 0x00000005, done one cycle after acceptance, div_use never asserted; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
- startE pulsed with new operands 5 cycles into CALC -> ignored, first result unchanged; second request accepted after done completes.
- rst=0 at CALC iteration 10 -> next cycle done=0, div_use=0, result_divide=0; a fresh DIVU 9/3 then returns 3 with full latency.
- With DIV_EARLY_TERM_EN: DIVU 3/10 -> 0 one cycle after acceptance; REM 0xFFFFFFFD/10 -> 0xFFFFFFFD. Without the macro, same values after 34 edges.
